// File: rtl/core_seq.sv
// Instruction sequencer: IP register, jumps, CALL/RET return stack, vectored interrupts, store stall.
// One command per cycle in RUN; LDS/STS stall in WAIT until store_busy drops, then IP+1.
module core_seq #(
  parameter int                DATA_W    = 16,
  parameter int                OPC_W     = 5,
  parameter int                STK_DEPTH = 8,
  parameter int                INT_N     = 16,
  parameter logic [DATA_W-1:0] VEC_BASE  = 'h0010
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [OPC_W+DATA_W-1:0]     CMD,
  output logic [DATA_W-1:0]           IP,
  input  logic                        fl_zf,
  input  logic                        fl_cf,
  input  logic                        int_req,
  input  logic [$clog2(INT_N)-1:0]    num_int,
  output logic                        int_ack,
  output logic                        int_en,
  output logic                        store_read,
  output logic                        store_write,
  input  logic                        store_busy,
  output logic                        stall,
  output logic [$clog2(STK_DEPTH):0]  stk_cnt,
  output logic                        stk_err
);

  localparam int AW = $clog2(STK_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_BREQ = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_BRNE = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_BRCS = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_BRCC = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_CALL = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_RETI = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_EI   = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_DI   = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_LDS  = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_STS  = OPC_W'(12);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ip_q, ip_d, ip_inc, push_val, dat;
  logic [OPC_W-1:0]    opc;
  logic                en_q, en_d, ack_q, ack_d, err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   stk_mem [STK_DEPTH];
  logic [AW-1:0]       top_idx, wr_idx;
  logic                full, empty, push, pop, wr_en, irq_take, st_rd, st_wr;

  assign opc      = CMD[OPC_W+DATA_W-1 -: OPC_W];
  assign dat      = CMD[DATA_W-1:0];
  assign ip_inc   = ip_q + DATA_W'(1);
  assign full     = (cnt_q == CW'(STK_DEPTH));
  assign empty    = (cnt_q == '0);
  assign top_idx  = AW'(cnt_q - CW'(1));
  assign wr_idx   = AW'(cnt_q);
  // ack_q blocks back-to-back entries from the same held request level
  assign irq_take = (state_q == S_RUN) && int_req && en_q && !ack_q;

  always_comb begin
    state_d  = state_q;
    ip_d     = ip_q;
    en_d     = en_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ack_d    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    push_val = ip_inc;
    st_rd    = 1'b0;
    st_wr    = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (irq_take) begin
          push     = 1'b1;
          push_val = ip_q;
          ip_d     = VEC_BASE + DATA_W'(num_int);
          en_d     = 1'b0;
          ack_d    = 1'b1;
        end else begin
          ip_d = ip_inc;
          case (opc)
            OP_JMP:  ip_d = dat;
            OP_BREQ: if (fl_zf)  ip_d = dat;
            OP_BRNE: if (!fl_zf) ip_d = dat;
            OP_BRCS: if (fl_cf)  ip_d = dat;
            OP_BRCC: if (!fl_cf) ip_d = dat;
            OP_CALL: begin push = 1'b1; ip_d = dat; end
            OP_RET:  pop = 1'b1;
            OP_RETI: begin pop = 1'b1; en_d = 1'b1; end
            OP_EI:   en_d = 1'b1;
            OP_DI:   en_d = 1'b0;
            OP_LDS:  begin st_rd = 1'b1; ip_d = ip_q; state_d = S_WAIT; end
            OP_STS:  begin st_wr = 1'b1; ip_d = ip_q; state_d = S_WAIT; end
            default: ;
          endcase
        end
      end
      S_WAIT: begin
        if (!store_busy) begin
          ip_d    = ip_inc;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
    // Overflow drops the push but keeps the jump; underflow falls through to IP+1
    if (push) begin
      if (full) err_d = 1'b1;
      else begin
        wr_en = 1'b1;
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (pop) begin
      if (empty) err_d = 1'b1;
      else begin
        ip_d  = stk_mem[top_idx];
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_RUN;
      ip_q    <= '0;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) stk_mem[wr_idx] <= push_val;
  end

  assign IP          = ip_q;
  assign int_en      = en_q;
  assign int_ack     = ack_q;
  assign stk_cnt     = cnt_q;
  assign stk_err     = err_q;
  assign stall       = (state_q == S_WAIT);
  assign store_read  = st_rd & RESET;
  assign store_write = st_wr & RESET;

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: directed scenarios plus randomized run against a queue-based reference model.
module tb_core_seq;

  localparam logic [4:0] NOP = 5'd0, JMP = 5'd1, CALL = 5'd6, RET = 5'd7, RETI = 5'd8;
  localparam logic [4:0] EI = 5'd9, LDS = 5'd11, STS = 5'd12;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [20:0] CMD;
  logic [15:0] IP;
  logic        fl_zf, fl_cf, int_req, int_ack, int_en;
  logic [3:0]  num_int;
  logic        store_read, store_write, store_busy, stall;
  logic [3:0]  stk_cnt;
  logic        stk_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_ip;
  bit          m_en, m_err, m_wait, m_ack;
  logic [15:0] m_stk [$];

  always #5 CLK = ~CLK;

  core_seq dut (
    .CLK(CLK), .RESET(RESET), .CMD(CMD), .IP(IP), .fl_zf(fl_zf), .fl_cf(fl_cf),
    .int_req(int_req), .num_int(num_int), .int_ack(int_ack), .int_en(int_en),
    .store_read(store_read), .store_write(store_write), .store_busy(store_busy),
    .stall(stall), .stk_cnt(stk_cnt), .stk_err(stk_err)
  );

  task automatic m_push(input logic [15:0] v);
    if (m_stk.size() == 8) m_err = 1'b1;
    else m_stk.push_back(v);
  endtask

  task automatic m_pop();
    if (m_stk.size() == 0) begin
      m_err = 1'b1;
      m_ip  = m_ip + 16'd1;
    end else m_ip = m_stk.pop_back();
  endtask

  task automatic model_step(input logic [4:0] op, input logic [15:0] d);
    bit take;
    take  = !m_wait && int_req && m_en && !m_ack;
    m_ack = take;
    if (m_wait) begin
      if (!store_busy) begin
        m_ip   = m_ip + 16'd1;
        m_wait = 1'b0;
      end
    end else if (take) begin
      m_push(m_ip);
      m_ip = 16'h0010 + 16'(num_int);
      m_en = 1'b0;
    end else begin
      case (op)
        5'd1:  m_ip = d;
        5'd2:  m_ip = fl_zf  ? d : m_ip + 16'd1;
        5'd3:  m_ip = !fl_zf ? d : m_ip + 16'd1;
        5'd4:  m_ip = fl_cf  ? d : m_ip + 16'd1;
        5'd5:  m_ip = !fl_cf ? d : m_ip + 16'd1;
        5'd6:  begin m_push(m_ip + 16'd1); m_ip = d; end
        5'd7:  m_pop();
        5'd8:  begin m_pop(); m_en = 1'b1; end
        5'd9:  begin m_en = 1'b1; m_ip = m_ip + 16'd1; end
        5'd10: begin m_en = 1'b0; m_ip = m_ip + 16'd1; end
        5'd11, 5'd12: m_wait = 1'b1;
        default: m_ip = m_ip + 16'd1;
      endcase
    end
  endtask

  task automatic do_reset();
    CMD = '0; fl_zf = 0; fl_cf = 0; int_req = 0; num_int = 0; store_busy = 0;
    RESET = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    m_ip = '0; m_en = 0; m_err = 0; m_wait = 0; m_ack = 0; m_stk = {};
  endtask

  task automatic exec(input logic [20:0] c);
    CMD = c;
    #1;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    do_reset();
    exec({EI, 16'h0});
    exec({CALL, 16'h0123});
    CMD = {LDS, 16'h0}; int_req = 1'b1;
    RESET = 1'b0;
    #2;
    checks++;
    if ({IP, int_en, stk_cnt, stk_err, int_ack, stall, store_read, store_write} !== 26'd0)
      $display("FAIL reset_outs: got IP=%h en=%b cnt=%0d err=%b ack=%b stall=%b rd=%b wr=%b, expected all zero",
               IP, int_en, stk_cnt, stk_err, int_ack, stall, store_read, store_write);
    if ({IP, int_en, stk_cnt, stk_err, int_ack, stall, store_read, store_write} !== 26'd0) errors++;
    RESET = 1'b1; int_req = 1'b0; CMD = '0;
  endtask

  task automatic test_seq_jmp();
    do_reset();
    checks++;
    if (IP !== 16'h0) begin errors++; $display("FAIL seq_ip0: got %h expected 0000", IP); end
    for (int i = 1; i <= 4; i++) begin
      exec({NOP, 16'hBEEF});
      checks++;
      if (IP !== 16'(i)) begin errors++; $display("FAIL seq_nop: got %h expected %h", IP, 16'(i)); end
    end
    exec({JMP, 16'h0100});
    checks++;
    if (IP !== 16'h0100) begin errors++; $display("FAIL jmp: got %h expected 0100", IP); end
  endtask

  task automatic test_branch();
    bit tk;
    logic [15:0] exp;
    do_reset();
    for (int op = 2; op <= 5; op++) begin
      for (int f = 0; f < 2; f++) begin
        exec({JMP, 16'd5});
        fl_zf = (op < 4) ? f[0] : 1'($urandom);
        fl_cf = (op >= 4) ? f[0] : 1'($urandom);
        tk  = (op == 2 || op == 4) ? (f == 1) : (f == 0);
        exp = tk ? 16'h0040 : 16'h0006;
        exec({5'(op), 16'h0040});
        checks++;
        if (IP !== exp) begin
          errors++;
          $display("FAIL branch op=%0d flag=%0d: got %h expected %h", op, f, IP, exp);
        end
      end
    end
  endtask

  task automatic test_stack();
    logic [15:0] exp_q [$];
    logic [15:0] e;
    do_reset();
    exec({JMP, 16'h01F0});
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back((i == 0) ? 16'h01F1 : 16'h0200 + 16'(i));
      exec({CALL, 16'h0200 + 16'(i)});
      checks++;
      if (IP !== 16'h0200 + 16'(i)) begin errors++; $display("FAIL call_ip %0d: got %h expected %h", i, IP, 16'h0200 + 16'(i)); end
      checks++;
      if (stk_cnt !== 4'((i < 8) ? i + 1 : 8)) begin errors++; $display("FAIL call_cnt %0d: got %0d expected %0d", i, stk_cnt, (i < 8) ? i + 1 : 8); end
      checks++;
      if (stk_err !== (i == 8)) begin errors++; $display("FAIL call_err %0d: got %b expected %b", i, stk_err, (i == 8)); end
    end
    for (int j = 0; j < 8; j++) begin
      e = exp_q.pop_back();
      exec({RET, 16'h0});
      checks++;
      if (IP !== e) begin errors++; $display("FAIL ret_ip %0d: got %h expected %h", j, IP, e); end
      checks++;
      if (stk_cnt !== 4'(7 - j)) begin errors++; $display("FAIL ret_cnt %0d: got %0d expected %0d", j, stk_cnt, 7 - j); end
    end
    exec({RET, 16'h0});
    checks++;
    if ({IP, stk_cnt, stk_err} !== {16'h01F2, 4'd0, 1'b1})
      begin errors++; $display("FAIL ret_underflow: got ip=%h cnt=%0d err=%b expected 01f2 0 1", IP, stk_cnt, stk_err); end
  endtask

  task automatic test_interrupt();
    do_reset();
    exec({EI, 16'h0});
    exec({JMP, 16'h0020});
    int_req = 1'b1; num_int = 4'd3;
    exec({CALL, 16'h0300});
    checks++;
    if ({int_ack, IP, int_en, stk_cnt} !== {1'b1, 16'h0013, 1'b0, 4'd1})
      begin errors++; $display("FAIL irq_entry: got ack=%b ip=%h en=%b cnt=%0d expected 1 0013 0 1", int_ack, IP, int_en, stk_cnt); end
    num_int = 4'd5;
    exec({RETI, 16'h0});
    checks++;
    if ({int_ack, IP, int_en, stk_cnt} !== {1'b0, 16'h0020, 1'b1, 4'd0})
      begin errors++; $display("FAIL reti: got ack=%b ip=%h en=%b cnt=%0d expected 0 0020 1 0", int_ack, IP, int_en, stk_cnt); end
    exec({NOP, 16'h0});
    checks++;
    if ({int_ack, IP, int_en, stk_cnt} !== {1'b1, 16'h0015, 1'b0, 4'd1})
      begin errors++; $display("FAIL irq_after_reti: got ack=%b ip=%h en=%b cnt=%0d expected 1 0015 0 1", int_ack, IP, int_en, stk_cnt); end
    int_req = 1'b0;
    exec({NOP, 16'h0});
    checks++;
    if (int_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse: got %b expected 0", int_ack); end
  endtask

  task automatic test_store();
    int nst;
    do_reset();
    exec({EI, 16'h0});
    store_busy = 1'b1;
    CMD = {STS, 16'h0};
    #1;
    checks++;
    if ({store_write, store_read} !== 2'b10) begin errors++; $display("FAIL sts_pulse: got wr=%b rd=%b expected 1 0", store_write, store_read); end
    @(posedge CLK); #1;
    nst = stall ? 1 : 0;
    checks++;
    if ({store_write, IP} !== {1'b0, 16'h0001}) begin errors++; $display("FAIL wait_entry: got wr=%b ip=%h expected 0 0001", store_write, IP); end
    int_req = 1'b1; num_int = 4'd2;
    for (int k = 0; k < 2; k++) begin
      exec({NOP, 16'h0});
      if (stall) nst++;
      checks++;
      if ({IP, int_ack} !== {16'h0001, 1'b0}) begin errors++; $display("FAIL wait_hold %0d: got ip=%h ack=%b expected 0001 0", k, IP, int_ack); end
    end
    store_busy = 1'b0;
    exec({NOP, 16'h0});
    checks++;
    if (nst !== 3) begin errors++; $display("FAIL stall_len: got %0d expected 3", nst); end
    checks++;
    if ({stall, IP, int_ack} !== {1'b0, 16'h0002, 1'b0}) begin errors++; $display("FAIL release: got stall=%b ip=%h ack=%b expected 0 0002 0", stall, IP, int_ack); end
    exec({NOP, 16'h0});
    checks++;
    if ({IP, int_ack} !== {16'h0012, 1'b1}) begin errors++; $display("FAIL deferred_irq: got ip=%h ack=%b expected 0012 1", IP, int_ack); end
    int_req = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    exec({JMP, 16'hFFFF});
    exec({NOP, 16'h0});
    checks++;
    if (IP !== 16'h0000) begin errors++; $display("FAIL wrap: got %h expected 0000", IP); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    exec({EI, 16'h0});
    exec({CALL, 16'h0050});
    store_busy = 1'b1;
    exec({LDS, 16'h0});
    exec({NOP, 16'h0});
    checks++;
    if ({stall, IP} !== {1'b1, 16'h0050}) begin errors++; $display("FAIL pre_abort: got stall=%b ip=%h expected 1 0050", stall, IP); end
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if ({IP, int_en, stk_cnt, stk_err, int_ack, stall, store_read, store_write} !== 26'd0)
      begin errors++; $display("FAIL abort_outs: got IP=%h en=%b cnt=%0d stall=%b expected zero", IP, int_en, stk_cnt, stall); end
    #2;
    RESET = 1'b1;
    store_busy = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (IP !== 16'h0001) begin errors++; $display("FAIL post_abort: got %h expected 0001", IP); end
  endtask

  task automatic test_random();
    logic [4:0]  op;
    logic [15:0] d;
    bit          take, exp_rd, exp_wr;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op >= 13 && $urandom_range(0, 2) != 0) op = 5'($urandom_range(6, 9));
      d          = 16'($urandom);
      fl_zf      = 1'($urandom);
      fl_cf      = 1'($urandom);
      int_req    = ($urandom_range(0, 3) == 0);
      num_int    = 4'($urandom);
      store_busy = 1'($urandom);
      CMD = {op, d};
      #1;
      take   = !m_wait && int_req && m_en && !m_ack;
      exp_rd = !m_wait && !take && (op == LDS);
      exp_wr = !m_wait && !take && (op == STS);
      checks++;
      if ({store_read, store_write} !== {exp_rd, exp_wr})
        begin errors++; $display("FAIL rnd_store %0d: got rd=%b wr=%b expected %b %b", n, store_read, store_write, exp_rd, exp_wr); end
      model_step(op, d);
      @(posedge CLK); #1;
      checks++;
      if ({IP, int_en, stk_cnt, stk_err, int_ack, stall} !== {m_ip, m_en, 4'(m_stk.size()), m_err, m_ack, m_wait}) begin
        errors++;
        $display("FAIL rnd_state %0d op=%0d: got ip=%h en=%b cnt=%0d err=%b ack=%b stall=%b expected %h %b %0d %b %b %b",
                 n, op, IP, int_en, stk_cnt, stk_err, int_ack, stall,
                 m_ip, m_en, m_stk.size(), m_err, m_ack, m_wait);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq_jmp();
    test_branch();
    test_stack();
    test_interrupt();
    test_store();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_seq.md
# core_seq

Parametrised instruction sequencer for the MicroCPU core: the next generation of the core's IP machine. Owns the instruction pointer and adds conditional and unconditional jumps, hardware CALL/RET through a return-address stack of configurable depth, and vectored interrupt entry/exit. It also stalls on a store handshake. It sits between instruction memory (drives `IP`, receives `CMD`) and the core's decode/datapath, which supplies flags and the store busy line.

## Interface
Parameters:
- `DATA_W`, 16: IP width and command data-field width.
- `OPC_W`, 5: opcode field width (≥4).
- `STK_DEPTH`, 8: return-stack entries (≥2, power of two).
- `INT_N`, 16: interrupt source count; `num_int` width is clog2(INT_N).
- `VEC_BASE`, 'h0010: IP of interrupt vector 0; vector k at VEC_BASE+k.

Ports:
- `CLK` in 1: clock. All state changes on the rising edge.
- `RESET` in 1: reset, asynchronous, active-low.
- `CMD` in OPC_W+DATA_W: current command; opcode = top OPC_W bits, data = low DATA_W bits.
- `IP` out DATA_W: instruction pointer.
- `fl_zf`, `fl_cf` in 1 each: zero and carry flags, sampled when the command executes.
- `int_req` in 1: level interrupt request.
- `num_int` in clog2(INT_N): source number, sampled with `int_req`.
- `int_ack` out 1: one-cycle pulse on interrupt entry.
- `int_en` out 1: global interrupt enable.
- `store_read`, `store_write` out 1 each: one-cycle store request pulses.
- `store_busy` in 1: store in progress.
- `stall` out 1: high while the sequencer is in WAIT.
- `stk_cnt` out clog2(STK_DEPTH)+1: current stack occupancy.
- `stk_err` out 1: sticky stack overflow/underflow flag.

## Operation
Opcodes (values fixed):
- 0 NOP
- 1 JMP
- 2 BREQ (zf=1)
- 3 BRNE (zf=0)
- 4 BRCS (cf=1)
- 5 BRCC (cf=0)
- 6 CALL
- 7 RET
- 8 RETI
- 9 EI
- 10 DI
- 11 LDS
- 12 STS
- all others: behave as NOP (IP+1); this includes the ALU/MOV opcodes decoded elsewhere.

State machine RUN / WAIT:
- RUN, no interrupt taken: execute CMD.
  - JMP: IP←data.
  - Branch taken: IP←data; not taken: IP←IP+1.
  - CALL: push IP+1, IP←data.
  - RET: pop into IP.
  - RETI: pop into IP, int_en←1.
  - EI/DI: set/clear int_en, then IP+1.
  - LDS/STS: pulse store_read/store_write, hold IP, go to WAIT.
- WAIT: hold IP, stall=1. The first cycle with store_busy=0 sets IP←IP+1 and returns to RUN. store_busy is ignored in the request cycle itself.
- Interrupt entry, evaluated in RUN only:
  - Condition: int_req=1, int_en=1, and no int_ack pulse in the previous cycle.
  - Action: CMD is not executed. Push the current IP, IP←VEC_BASE+num_int, int_en←0, int_ack=1.
  - Interrupt entry has priority over every opcode, including CALL/RET and store requests.
  - Requests arriving in WAIT are deferred until the next RUN cycle.
- Stack: push when stk_cnt=STK_DEPTH discards the push and sets stk_err; the jump still happens. Pop when stk_cnt=0 sets stk_err and gives IP←IP+1 (RETI still sets int_en). stk_err clears only on reset.
- IP arithmetic is modulo 2^DATA_W. IP+1 at all-ones wraps to 0. VEC_BASE+num_int truncates to DATA_W.

## Timing
- Reset values:
  - IP=0, state RUN, int_en=0, stk_cnt=0, stk_err=0.
  - int_ack=0, store_read=0, store_write=0, stall=0.
  - Stack contents are don't-care.
- Reset asserted mid-WAIT or mid-interrupt aborts immediately to the reset values.
- One command per cycle in RUN: IP updates on the edge after CMD is presented. Zero-bubble jumps; IP is a register, no combinational path from CMD to IP.
- Store latency: request cycle, plus N busy cycles, plus 1 release cycle. Minimum 2 cycles per LDS/STS when store_busy stays low.
- int_ack and the vector IP appear on the same edge. The first vector instruction executes the next cycle.
- RETI sets int_en on its edge, so a pending int_req is taken the following cycle.

## Test plan
- Reset then 4 NOPs → IP 0,1,2,3,4. JMP data=0x0100 → IP=0x0100 next cycle.
- BREQ 0x40 at IP=5 with zf=0 → IP=6; repeat with zf=1 → IP=0x40. Same check for BRNE/BRCS/BRCC.
- STK_DEPTH=8: nested CALLs to 0x200..0x208 (9 calls) → stk_cnt saturates at 8, stk_err=1. 8 RETs return to the pushed IP+1 values in LIFO order. A 9th RET gives IP+1.
- EI; int_req=1, num_int=3 while CALL 0x300 is presented at IP=0x20 → int_ack pulse, IP=0x13, int_en=0, pushed value=0x20. RETI → IP=0x20, int_en=1.
- STS with store_busy high for 3 cycles; int_req asserted during WAIT → stall=1 for 3 cycles, IP held. IP+1 on release, interrupt taken the cycle after.
- IP=0xFFFF executing NOP → IP=0x0000. Reset asserted mid-WAIT → all outputs return to reset values asynchronously.
